// File: rtl/ssha256_pkg.sv
// Shared definitions for the scalar SHA-256 functional unit and its
// combinational core: op indices, rotate amounts and the op type.
package ssha256_pkg;

    localparam int OP_SIG0 = 0;
    localparam int OP_SIG1 = 1;
    localparam int OP_SUM0 = 2;
    localparam int OP_SUM1 = 3;

    localparam int SIG0_R0 = 7;
    localparam int SIG0_R1 = 18;
    localparam int SIG0_SH = 3;
    localparam int SIG1_R0 = 17;
    localparam int SIG1_R1 = 19;
    localparam int SIG1_SH = 10;
    localparam int SUM0_R0 = 2;
    localparam int SUM0_R1 = 13;
    localparam int SUM0_R2 = 22;
    localparam int SUM1_R0 = 6;
    localparam int SUM1_R1 = 11;
    localparam int SUM1_R2 = 25;

    typedef logic [3:0] ssha256_op_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/ssha256_core.sv
// Purely combinational SHA-256 sigma/sum evaluation. The op select is one-hot;
// each enabled function is OR-ed into the result, so op=0 yields 0.
module ssha256_core
    import ssha256_pkg::*;
(
    input  ssha256_op_t op_i,
    input  logic [31:0] x_i,
    output logic [31:0] result_o
);

    logic [31:0] sig0;
    logic [31:0] sig1;
    logic [31:0] sum0;
    logic [31:0] sum1;

    always_comb begin
        sig0 = ror32(x_i, SIG0_R0) ^ ror32(x_i, SIG0_R1) ^ (x_i >> SIG0_SH);
        sig1 = ror32(x_i, SIG1_R0) ^ ror32(x_i, SIG1_R1) ^ (x_i >> SIG1_SH);
        sum0 = ror32(x_i, SUM0_R0) ^ ror32(x_i, SUM0_R1) ^ ror32(x_i, SUM0_R2);
        sum1 = ror32(x_i, SUM1_R0) ^ ror32(x_i, SUM1_R1) ^ ror32(x_i, SUM1_R2);
        result_o = ({32{op_i[OP_SIG0]}} & sig0)
                 | ({32{op_i[OP_SIG1]}} & sig1)
                 | ({32{op_i[OP_SUM0]}} & sum0)
                 | ({32{op_i[OP_SUM1]}} & sum1);
    end

endmodule

// File: rtl/ssha256_fu.sv
// Two-stage valid/ready pipeline around ssha256_core: S1 captures the request,
// S2 holds the tagged result presented to writeback. Flush kills both stages.
module ssha256_fu
    import ssha256_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter bit          ZERO_RD = 1'b1
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  ssha256_op_t      in_op,
    input  logic [31:0]      in_rs1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers hold payload stable until accepted; S2 holds while stalled.
    logic             s1_valid_q;
    ssha256_op_t      s1_op_q;
    logic [31:0]      s1_rs1_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_valid_q;
    logic [31:0]      s2_result_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_adv;
    logic             in_fire;
    logic [31:0]      core_result;
    logic [31:0]      s2_result_d;

    ssha256_core u_core (
        .op_i     (s1_op_q),
        .x_i      (s1_rs1_q),
        .result_o (core_result)
    );

    always_comb begin
        s2_adv      = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_adv;
        in_fire     = in_valid && in_ready;
        s2_result_d = (ZERO_RD && (s1_tag_q == '0)) ? 32'h0 : core_result;
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid_q <= 1'b1;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    // Data only moves alongside a surviving valid, so out_result/out_tag
    // never change while out_valid is low.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            s1_op_q     <= '0;
            s1_rs1_q    <= '0;
            s1_tag_q    <= '0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else if (!flush) begin
            if (in_fire) begin
                s1_op_q  <= in_op;
                s1_rs1_q <= in_rs1;
                s1_tag_q <= in_tag;
            end
            if (s2_adv) begin
                s2_result_q <= s2_result_d;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_ssha256_fu.sv
// Scoreboard bench for ssha256_fu: directed scenarios plus random traffic
// checked against a plain-arithmetic SHA-256 sigma/sum model.
module tb_ssha256_fu;

    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [31:0]      cyc;
    } exp_t;

    logic             g_clk = 1'b0;
    logic             g_resetn = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [31:0]      in_rs1 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [31:0] cyc = '0;
    int          ready_mode = 1;
    bit          rand_flush = 1'b0;
    bit          lat_chk = 1'b0;

    bit               prev_hold = 1'b0;
    bit               prev_flush = 1'b0;
    logic [31:0]      prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;

    ssha256_fu #(.TAG_W(TAG_W), .ZERO_RD(1'b1)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    // clock / cycle counter
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference model
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x};
        return dbl[n +: 32];
    endfunction

    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] x,
                                              input logic [TAG_W-1:0] tag);
        logic [31:0] r;
        case (op)
            4'b0001: r = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
            4'b0010: r = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
            4'b0100: r = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
            4'b1000: r = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
            default: r = 32'h0;
        endcase
        if (tag == 0) r = 32'h0;
        return r;
    endfunction

    // monitor: decides the transfers of the coming edge from mid-cycle values
    always @(negedge g_clk) begin
        if (!g_resetn) begin
            prev_hold  = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (in_valid && !$onehot0(in_op)) $error("illegal non-one-hot in_op %b", in_op);
            if (prev_hold && !prev_flush) begin
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_result", out_result, prev_res);
                check("hold_tag", {27'h0, out_tag}, {27'h0, prev_tag});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_result, 32'hDEAD_DEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", out_result, e.res);
                    check("tag", {27'h0, out_tag}, {27'h0, e.tag});
                    if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_t e;
                e.res = ref_model(in_op, in_rs1, in_tag);
                e.tag = in_tag;
                e.cyc = cyc;
                exp_q.push_back(e);
                n_acc++;
            end
            prev_hold  = out_valid && !out_ready;
            prev_flush = flush;
            prev_res   = out_result;
            prev_tag   = out_tag;
        end
    end

    // consumer
    always @(posedge g_clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // driver: call at posedge+1; returns at posedge+1 after the request is taken
    task automatic drive_op(input logic [3:0] op, input logic [31:0] rs1, input logic [TAG_W-1:0] tag);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = rs1;
        in_tag   = tag;
        for (int i = 0; i < 200 && !got; i++) begin
            flush = rand_flush && ($urandom_range(0, 149) == 0);
            @(negedge g_clk);
            got = in_ready;
            @(posedge g_clk);
            #1;
        end
        if (!got) check("accept_timeout", 32'h0, 32'h1);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge g_clk);
            #1;
            i++;
        end
        check("drain_timeout", exp_q.size(), 32'h0);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] o;
        o = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 19) == 0) o = 4'b0000;
        return o;
    endfunction

    initial begin
        int base;
        logic [31:0] held;
        // reset state
        repeat (3) @(posedge g_clk);
        #2 g_resetn = 1'b1;
        @(negedge g_clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", {27'h0, out_tag}, 32'h0);
        @(posedge g_clk);
        #1;

        // back-to-back ops on rs1=1, latency 2
        ready_mode = 1;
        idle(1);
        lat_chk = 1'b1;
        drive_op(4'b0001, 32'h1, 5'd1);
        drive_op(4'b0010, 32'h1, 5'd2);
        drive_op(4'b0100, 32'h1, 5'd3);
        drive_op(4'b1000, 32'h1, 5'd4);
        wait_drain(20);
        check("known_sig0", ref_model(4'b0001, 32'h1, 5'd1), 32'h02004000);
        check("known_sum1", ref_model(4'b1000, 32'h1, 5'd4), 32'h04200080);
        lat_chk = 1'b0;

        // backpressure: 3 ops offered, only 2 fit
        ready_mode = 0;
        idle(1);
        base = n_acc;
        fork
            begin
                drive_op(4'b0100, 32'hA5A5_1234, 5'd7);
                drive_op(4'b0001, 32'h8000_0001, 5'd8);
                drive_op(4'b1000, 32'h1357_9BDF, 5'd9);
            end
        join_none
        repeat (5) @(posedge g_clk);
        @(negedge g_clk);
        check("bp_accepts", n_acc - base, 32'd2);
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_out_valid", {31'h0, out_valid}, 32'h1);
        held = out_result;
        @(posedge g_clk);
        #2;
        ready_mode = 1;
        check("bp_out_stable", out_result, held);
        wait fork;
        wait_drain(20);
        check("bp_all_out", n_acc - base, 32'd3);

        // flush with same-cycle accept while S1 and S2 are full
        ready_mode = 0;
        idle(1);
        drive_op(4'b0001, 32'hCAFE_0001, 5'd10);
        drive_op(4'b0010, 32'hCAFE_0002, 5'd11);
        ready_mode = 1;
        @(posedge g_clk);
        #2;
        in_valid = 1'b1;
        in_op    = 4'b0100;
        in_rs1   = 32'hCAFE_0003;
        in_tag   = 5'd12;
        flush    = 1'b1;
        @(negedge g_clk);
        check("flush_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge g_clk);
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);
        idle(6);
        drive_op(4'b1000, 32'h0BAD_F00D, 5'd13);
        wait_drain(20);

        // x0 destination
        drive_op(4'b0100, 32'hFFFF_FFFF, 5'd0);
        drive_op(4'b0100, 32'hFFFF_FFFF, 5'd5);
        wait_drain(20);
        check("known_zero_rd", ref_model(4'b0100, 32'hFFFF_FFFF, 5'd5), 32'hFFFF_FFFF);

        // async reset mid-stream
        ready_mode = 0;
        drive_op(4'b0001, 32'h1111_2222, 5'd3);
        drive_op(4'b0010, 32'h3333_4444, 5'd4);
        #2 g_resetn = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
        @(posedge g_clk);
        #2 g_resetn = 1'b1;
        @(negedge g_clk);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
        @(posedge g_clk);
        #1;

        // random traffic with random backpressure and occasional flushes
        ready_mode = 2;
        rand_flush = 1'b1;
        base = n_out;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            drive_op(rand_op(), $urandom, TAG_W'($urandom_range(0, 31)));
        end
        rand_flush = 1'b0;
        ready_mode = 1;
        wait_drain(50);
        checks++;
        if (n_out - base < 5000) begin
            errors++;
            $display("FAIL random_outputs: got %0d expected at least 5000", n_out - base);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
